// File: rtl/fifo_sched_wrr.sv
// Weighted round-robin drain of CHN_NUM registered-output FIFOs onto one valid/ready stream.
// state | meaning:  IDLE wait/grant | READ pulse rd_en | LOAD capture rd data | SEND hold word until accepted
module fifo_sched_wrr #(
    parameter int CHN_NUM    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int WGHT_WIDTH = 4,
    parameter int CHN_WIDTH  = $clog2(CHN_NUM)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [CHN_NUM-1:0]               i_fifo_empty,
    output logic [CHN_NUM-1:0]               o_fifo_rd_en,
    input  logic [CHN_NUM*DATA_WIDTH-1:0]    i_fifo_rd_data,
    input  logic [CHN_NUM*WGHT_WIDTH-1:0]    i_wght,
    output logic                             o_valid,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [CHN_WIDTH-1:0]             o_chn,
    input  logic                             i_ready,
    output logic                             o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LOAD = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CHN_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CHN_WIDTH-1:0]   chn_q, chn_d;
    logic [WGHT_WIDTH-1:0]  quota_q, quota_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;

    logic [CHN_NUM-1:0]     elig;
    logic                   grant_vld;
    logic [CHN_WIDTH-1:0]   grant_chn;
    logic [WGHT_WIDTH-1:0]  grant_wght;
    logic [WGHT_WIDTH-1:0]  quota_dec;
    logic [CHN_NUM-1:0]     rd_en;
    logic                   valid;

    always_comb begin
        elig = '0;
        for (int k = 0; k < CHN_NUM; k++) begin
            elig[k] = !i_fifo_empty[k] && (i_wght[k*WGHT_WIDTH +: WGHT_WIDTH] != '0);
        end
    end

    // First eligible channel at or above the pointer, wrapping modulo CHN_NUM.
    always_comb begin
        grant_vld = 1'b0;
        grant_chn = '0;
        for (int i = 0; i < CHN_NUM; i++) begin
            if (!grant_vld && elig[(int'(ptr_q) + i) % CHN_NUM]) begin
                grant_vld = 1'b1;
                grant_chn = CHN_WIDTH'((int'(ptr_q) + i) % CHN_NUM);
            end
        end
    end

    assign grant_wght = i_wght[grant_chn*WGHT_WIDTH +: WGHT_WIDTH];
    assign quota_dec  = quota_q - WGHT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        chn_d   = chn_q;
        quota_d = quota_q;
        data_d  = data_q;
        rd_en   = '0;
        valid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    chn_d   = grant_chn;
                    quota_d = grant_wght;
                    state_d = READ;
                end
            end
            READ: begin
                rd_en   = CHN_NUM'(1) << chn_q;
                state_d = LOAD;
            end
            LOAD: begin
                data_d  = i_fifo_rd_data[chn_q*DATA_WIDTH +: DATA_WIDTH];
                state_d = SEND;
            end
            SEND: begin
                valid = 1'b1;
                if (i_ready) begin
                    quota_d = quota_dec;
                    if (quota_dec != '0 && !i_fifo_empty[chn_q]) begin
                        state_d = READ;
                    end else begin
                        ptr_d   = (chn_q == CHN_WIDTH'(CHN_NUM - 1)) ? '0 : chn_q + CHN_WIDTH'(1);
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            chn_q   <= '0;
            quota_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            chn_q   <= chn_d;
            quota_q <= quota_d;
            data_q  <= data_d;
        end
    end

    assign o_fifo_rd_en = rd_en;
    assign o_valid      = valid;
    assign o_data       = data_q;
    assign o_chn        = chn_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_sched_wrr.sv
// Bench for fifo_sched_wrr: emulated registered-output FIFOs, table vectors, corner sequences, random runs vs. a queue model.
module tb_fifo_sched_wrr;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    fifo_empty;
    logic [3:0]    rd_en;
    logic [127:0]  rd_data;
    logic [15:0]   wght;
    logic          valid;
    logic [31:0]   data;
    logic [1:0]    chn;
    logic          ready;
    logic          busy;

    always #5 clk = ~clk;

    fifo_sched_wrr #(.CHN_NUM(4), .DATA_WIDTH(32), .WGHT_WIDTH(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_rd_en   (rd_en),
        .i_fifo_rd_data (rd_data),
        .i_wght         (wght),
        .o_valid        (valid),
        .o_data         (data),
        .o_chn          (chn),
        .i_ready        (ready),
        .o_busy         (busy)
    );

    typedef struct packed {
        logic [15:0] wght;
        logic [15:0] cnt;
        logic [5:0]  n_exp;
        logic [31:0] seq;
        logic [15:0] reads;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int run    = 0;
    int rdy_pct = 100;

    logic [31:0] fq     [4][$];
    logic [31:0] loaded [4][$];
    int          got_chn[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    int          rd_cyc[$];
    int          rd_cnt [4];
    int          exp_q[$];

    logic        prev_valid, prev_hs;
    logic [31:0] prev_data;
    logic [1:0]  prev_chn;

    function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic load(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = (32'(k) << 28) | (32'(run & 255) << 16) | 32'(i);
            fq[k].push_back(w);
            loaded[k].push_back(w);
        end
        fifo_empty[k] = (fq[k].size() == 0);
    endtask

    task automatic cycle();
        logic [3:0] rd_s;
        logic       hs;
        @(negedge clk);
        ready = ($urandom_range(99) < rdy_pct);
        cyc++;
        rd_s = rd_en;
        hs   = valid && ready;
        chk($countones(rd_en) <= 1, "rd_onehot", 64'(rd_en), 64'(0));
        chk((rd_en & fifo_empty) == 4'b0, "rd_on_empty", 64'(rd_en), 64'(~fifo_empty));
        if (prev_valid && !prev_hs)
            chk(valid && data == prev_data && chn == prev_chn, "hold_stable",
                {31'b0, valid, chn, data}, {31'b0, 1'b1, prev_chn, prev_data});
        if (valid)
            chk(rd_en == 4'b0 && busy, "send_quiet", 64'({busy, rd_en}), 64'h10);
        if (hs) begin
            got_chn.push_back(int'(chn));
            got_data.push_back(data);
            got_cyc.push_back(cyc);
        end
        for (int k = 0; k < 4; k++) if (rd_en[k]) rd_cnt[k]++;
        if (rd_en != 4'b0) rd_cyc.push_back(cyc);
        prev_valid = valid;
        prev_hs    = hs;
        prev_data  = data;
        prev_chn   = chn;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (rd_s[k]) begin
                if (fq[k].size() > 0) rd_data[k*32 +: 32] = fq[k].pop_front();
                fifo_empty[k] = (fq[k].size() == 0);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fq[k].delete();
            loaded[k].delete();
            rd_cnt[k] = 0;
        end
        fifo_empty = 4'hF;
        rd_data    = '0;
        got_chn.delete();
        got_data.delete();
        got_cyc.delete();
        rd_cyc.delete();
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run++;
    endtask

    task automatic drain(input int n, input int budget);
        int b;
        b = budget;
        while (got_chn.size() < n && b > 0) begin
            cycle();
            b--;
        end
        chk(got_chn.size() == n, "drain_count", 64'(got_chn.size()), 64'(n));
        repeat (8) cycle();
        chk(!busy && got_chn.size() == n, "drain_idle", 64'({busy, 16'(got_chn.size())}), 64'(n));
    endtask

    task automatic wait_valid(input int budget);
        int b;
        b = budget;
        while (!valid && b > 0) begin
            cycle();
            b--;
        end
        chk(valid, "wait_valid", 64'(valid), 64'(1));
    endtask

    task automatic check_seq();
        int idx[4];
        logic [31:0] ed;
        for (int k = 0; k < 4; k++) idx[k] = 0;
        chk(got_chn.size() == exp_q.size(), "seq_len", 64'(got_chn.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_chn.size(); i++) begin
            int k;
            k = exp_q[i];
            ed = (idx[k] < loaded[k].size()) ? loaded[k][idx[k]] : 32'hDEAD_BEEF;
            idx[k]++;
            chk(got_chn[i] == k, "seq_chn", 64'(got_chn[i]), 64'(k));
            chk(got_data[i] == ed, "seq_data", 64'(got_data[i]), 64'(ed));
        end
    endtask

    // Reference: serve bursts of up to weight words from the first non-empty, non-masked channel at/after the pointer.
    task automatic model(input logic [15:0] w);
        int c[4];
        int ptr, found, q;
        exp_q.delete();
        for (int k = 0; k < 4; k++) c[k] = loaded[k].size();
        ptr = 0;
        forever begin
            found = -1;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (ptr + i) % 4;
                if (found < 0 && c[k] > 0 && w[4*k +: 4] != 4'd0) found = k;
            end
            if (found < 0) break;
            q = int'(w[4*found +: 4]);
            while (q > 0 && c[found] > 0) begin
                exp_q.push_back(found);
                c[found]--;
                q--;
            end
            ptr = (found + 1) % 4;
        end
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{wght: 16'h1111, cnt: 16'h2222, n_exp: 6'd8,  seq: 32'h0000_E4E4, reads: 16'h2222};
        vecs[1] = '{wght: 16'h2013, cnt: 16'h4626, n_exp: 6'd12, seq: 32'h00F4_0F40, reads: 16'h4026};
        vecs[2] = '{wght: 16'h1141, cnt: 16'h1020, n_exp: 6'd3,  seq: 32'h0000_0035, reads: 16'h1020};
        vecs[3] = '{wght: 16'h2111, cnt: 16'h3001, n_exp: 6'd4,  seq: 32'h0000_00FC, reads: 16'h3001};

        ready = 1'b0;
        wght  = '0;
        do_reset();
        #1;
        chk({valid, data, chn, rd_en, busy} == '0, "reset_state",
            64'({valid, chn, rd_en, busy}) | (64'(data) << 8), 64'(0));

        // Async reset mid-SEND after the pointer has moved to 2; next grant must restart at ch0.
        wght    = 16'h0211;
        load(1, 1);
        load(2, 2);
        rdy_pct = 100;
        begin
            int b;
            b = 50;
            while (got_chn.size() < 1 && b > 0) begin cycle(); b--; end
        end
        rdy_pct = 0;
        wait_valid(20);
        chk(chn == 2'd2, "pre_rst_chn", 64'(chn), 64'(2));
        rst_n = 1'b0;
        #1;
        chk({valid, chn, rd_en, busy} == '0 && data == '0, "async_rst",
            64'({valid, chn, rd_en, busy}) | (64'(data) << 8), 64'(0));
        do_reset();
        load(0, 1);
        load(2, 1);
        rdy_pct = 100;
        drain(2, 100);
        exp_q = '{0, 2};
        check_seq();

        // Single channel, quota 2 then regrant: latency and read-enable timing.
        do_reset();
        wght = 16'h0200;
        load(2, 3);
        rdy_pct = 100;
        drain(3, 100);
        exp_q = '{2, 2, 2};
        check_seq();
        chk(rd_cnt[2] == 3 && rd_cnt[0] + rd_cnt[1] + rd_cnt[3] == 0, "single_reads",
            64'(rd_cnt[2]), 64'(3));
        chk(rd_cyc.size() == 3 && got_cyc.size() == 3, "single_events", 64'(rd_cyc.size()), 64'(3));
        if (got_cyc.size() == 3) begin
            chk(got_cyc[1] - got_cyc[0] == 3, "burst_gap", 64'(got_cyc[1] - got_cyc[0]), 64'(3));
            chk(got_cyc[2] - got_cyc[1] == 4, "regrant_gap", 64'(got_cyc[2] - got_cyc[1]), 64'(4));
        end
        for (int i = 0; i < 3 && i < rd_cyc.size() && i < got_cyc.size(); i++)
            chk(got_cyc[i] == rd_cyc[i] + 2, "rd_to_valid", 64'(got_cyc[i] - rd_cyc[i]), 64'(2));

        // Table vectors: round robin, weighted with masked channel, early empty, pointer wrap.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            wght = vecs[v].wght;
            for (int k = 0; k < 4; k++) load(k, int'(vecs[v].cnt[4*k +: 4]));
            rdy_pct = 75;
            drain(int'(vecs[v].n_exp), 2000);
            exp_q.delete();
            for (int i = 0; i < int'(vecs[v].n_exp); i++) exp_q.push_back(int'(vecs[v].seq[2*i +: 2]));
            check_seq();
            for (int k = 0; k < 4; k++)
                chk(rd_cnt[k] == int'(vecs[v].reads[4*k +: 4]), "vec_reads",
                    64'(rd_cnt[k]), 64'(vecs[v].reads[4*k +: 4]));
        end

        // Backpressure: word held for 5 cycles with ready low, then accepted.
        do_reset();
        wght = 16'h0001;
        load(0, 1);
        rdy_pct = 0;
        wait_valid(20);
        repeat (5) begin
            cycle();
            chk(valid && data == loaded[0][0] && chn == 2'd0 && rd_en == 4'b0, "bp_hold",
                64'({valid, chn, rd_en}) | (64'(data) << 8), 64'({1'b1, 2'd0, 4'd0}) | (64'(loaded[0][0]) << 8));
        end
        rdy_pct = 100;
        drain(1, 20);
        exp_q = '{0};
        check_seq();

        // Randomized weights, depths and backpressure against the queue model.
        for (int r = 0; r < 30; r++) begin
            do_reset();
            for (int k = 0; k < 4; k++) wght[4*k +: 4] = 4'($urandom_range(4));
            for (int k = 0; k < 4; k++) load(k, int'($urandom_range(5)));
            model(wght);
            rdy_pct = int'($urandom_range(90, 30));
            drain(exp_q.size(), 3000);
            check_seq();
            for (int k = 0; k < 4; k++) begin
                int n;
                n = 0;
                foreach (exp_q[i]) if (exp_q[i] == k) n++;
                chk(rd_cnt[k] == n, "rand_reads", 64'(rd_cnt[k]), 64'(n));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/fifo_sched_wrr.md
Name: fifo_sched_wrr

Overview:
- Weighted round-robin read scheduler that drains CHN_NUM synchronous FIFOs (fifo_mode_s instances) onto one valid/ready output stream.
- Sits between per-source queues and a shared downstream consumer (bus master, packer).
- Is the only agent driving the FIFO read enables.
- Captures each FIFO's registered read data and tags it with its channel index.

Parameters:
- CHN_NUM, 4, number of FIFO channels (>=2).
- DATA_WIDTH, 32, FIFO word width.
- WGHT_WIDTH, 4, width of each per-channel weight (burst quota).
- CHN_WIDTH, $clog2(CHN_NUM), channel index width.

Ports:
- i_clk  in  1  clock; one clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_fifo_empty  in  CHN_NUM  per-channel FIFO empty flag.
- o_fifo_rd_en  out  CHN_NUM  per-channel FIFO read enable; one-hot or zero.
- i_fifo_rd_data  in  CHN_NUM*DATA_WIDTH  flattened FIFO read data; channel k at [k*DATA_WIDTH +: DATA_WIDTH].
- i_wght  in  CHN_NUM*WGHT_WIDTH  per-channel weight; channel k at [k*WGHT_WIDTH +: WGHT_WIDTH].
- o_valid  out  1  output word valid.
- o_data  out  DATA_WIDTH  output word.
- o_chn  out  CHN_WIDTH  source channel of o_data.
- i_ready  in  1  downstream accepts the word when o_valid && i_ready.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE; rr pointer=0; quota=0.
  - o_valid=0, o_data=0, o_chn=0, o_fifo_rd_en=0, o_busy=0.
  - No partial word is retained.
- Eligibility: channel k is eligible when !i_fifo_empty[k] && weight[k]!=0. Weight 0 masks the channel.
- IDLE:
  - If any channel is eligible, grant the first eligible channel searching upward from the rr pointer, with modulo CHN_NUM wrap.
  - Latch the grant into r_chn and o_chn; load quota=weight[r_chn]; go to READ.
  - Otherwise stay in IDLE.
- READ (1 cycle):
  - o_fifo_rd_en[r_chn]=1; all other read enables are 0.
  - Go to LOAD.
- LOAD (1 cycle):
  - The FIFO read data is now valid; register i_fifo_rd_data[r_chn] into o_data.
  - Go to SEND.
- SEND:
  - o_valid=1. o_data and o_chn are held stable while i_ready=0. No read enables are asserted.
  - On o_valid && i_ready, quota decrements by 1.
    - If the new quota is !=0 && !i_fifo_empty[r_chn] (sampled in the handshake cycle): go to READ on the same channel.
    - Otherwise: rr pointer=(r_chn+1) mod CHN_NUM, go to IDLE.
  - o_valid deasserts in the cycle after the handshake.
- Latency and throughput:
  - Grant in IDLE to o_valid is 3 cycles (IDLE→READ→LOAD→SEND).
  - Within a burst, one word every 3 cycles with i_ready=1.
  - Between bursts, one extra IDLE cycle.
- Weight sampling: weights are sampled only at grant. Changes mid-burst take effect at the next grant of that channel.
- Wrap-around: the rr pointer wraps CHN_NUM-1 → 0. Quota arithmetic is WGHT_WIDTH wide and never underflows, because quota≥1 whenever in SEND.
- FIFO empty during a burst: the burst ends early; the remaining quota is discarded.
- Reading an empty FIFO: never issued, because the read enable is only asserted for a channel seen non-empty at grant or at the handshake, and this block is the sole reader.
- No eligible channel: the block stays in IDLE with all read enables at 0.
- o_busy = (state != IDLE).

Test Plan:
1. Reset: assert i_rst_n=0 mid-SEND with o_valid=1 → o_valid, o_data, o_chn, o_fifo_rd_en and o_busy all go to 0 immediately. After release, the first grant starts from channel 0.
2. Single channel: ch2 holds words A, B, C with wght2=2; other channels empty; i_ready=1.
   - Output A, B tagged chn=2. o_fifo_rd_en=4'b0100 exactly one cycle before each LOAD.
   - Then IDLE for 1 cycle, regrant to ch2, output C.
   - o_valid goes high 3 cycles after each grant.
3. Round robin: all 4 FIFOs full, all weights=1 → o_chn sequence 0,1,2,3,0,1… with no channel repeated before the others are served.
4. Weighted: weights {3,1,0,2} for ch0..3, all FIFOs deep → o_chn sequence 0,0,0,1,3,3,0,0,0,1,3,3. Ch2 o_fifo_rd_en is never asserted.
5. Backpressure: hold i_ready=0 for 5 cycles in SEND → o_valid=1, and o_data and o_chn are unchanged every cycle. o_fifo_rd_en=0 throughout. The word completes when i_ready rises.
6. Early empty: ch1 with wght=4 holds 2 words; ch3 has data → ch1 outputs 2 words. After the second handshake the block goes to IDLE and the next grant is ch3 (pointer=2, ch2 empty). Total ch1 reads = 2.
